// File: rtl/timer_array.sv
// ---------------------------------------------------------------------------
// timer_array
//   NCH independent timer channels, each with a prescaler, an up-counter and
//   a compare register, behind a simple Wishbone-style word-addressed slave.
//   A tick is produced every (presc+1) enabled cycles. On a tick the counter
//   either advances or, when it equals the compare value, wraps to 0 and sets
//   the channel's sticky match flag. In one-shot mode a match also clears en.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   i_wb_adr   : word address; MSB=1 selects global space, else {channel, reg}
//   i_wb_dat   : write data
//   i_wb_we    : write enable
//   i_wb_cyc   : bus cycle request
//   o_wb_rdt   : read data, combinational from i_wb_adr
//   o_wb_ack   : acknowledge, one cycle after cyc, never on two cycles in a row
//   o_int_vec  : per-channel interrupt (match flag & ie)
//   o_int      : OR of o_int_vec
//
// Register map
//   channel reg0 CTRL    {presc[8+PW-1:8], ie[2], oneshot[1], en[0]}
//   channel reg1 CMP
//   channel reg2 CNT     (read-write)
//   channel reg3 PRE_CNT (read-only prescaler value)
//   global  word0 STATUS (match flags, write-1-to-clear)
//   global  word1 ID     {NCH[15:0], PW[7:0], CW[7:0]}
// ---------------------------------------------------------------------------
module timer_array #(
   parameter int NCH = 4,
   parameter int CW  = 32,
   parameter int PW  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [$clog2(NCH)+2:0] i_wb_adr,
   input  logic [31:0]            i_wb_dat,
   input  logic                   i_wb_we,
   input  logic                   i_wb_cyc,
   output logic [31:0]            o_wb_rdt,
   output logic                   o_wb_ack,
   output logic [NCH-1:0]         o_int_vec,
   output logic                   o_int
);

   localparam int AW  = $clog2(NCH) + 3;
   // Keep the channel index at least one bit wide so NCH=1 still elaborates.
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0]    R_CTRL   = 2'd0;
   localparam logic [1:0]    R_CMP    = 2'd1;
   localparam logic [1:0]    R_CNT    = 2'd2;
   localparam logic [1:0]    R_PRE    = 2'd3;
   localparam logic [AW-2:0] G_STATUS = (AW-1)'(0);
   localparam logic [AW-2:0] G_ID     = (AW-1)'(1);

   // Architectural state
   logic           ack_q,    ack_d;
   logic [NCH-1:0] status_q, status_d;
   logic [NCH-1:0] en_q,     en_d;
   logic [NCH-1:0] os_q,     os_d;
   logic [NCH-1:0] ie_q,     ie_d;
   logic [PW-1:0]  presc_q [NCH];
   logic [PW-1:0]  presc_d [NCH];
   logic [PW-1:0]  pre_q   [NCH];
   logic [PW-1:0]  pre_d   [NCH];
   logic [CW-1:0]  cmp_q   [NCH];
   logic [CW-1:0]  cmp_d   [NCH];
   logic [CW-1:0]  cnt_q   [NCH];
   logic [CW-1:0]  cnt_d   [NCH];

   // Decode
   logic           glob_s;
   logic [AW-2:0]  low_s;
   logic [CHW-1:0] ch_s;
   logic [1:0]     reg_s;
   logic           wr_s;
   logic           w1c_s;
   logic [NCH-1:0] ctl_wr_s;
   logic [NCH-1:0] cmp_wr_s;
   logic [NCH-1:0] cnt_wr_s;
   logic [NCH-1:0] tick_s;
   logic [NCH-1:0] match_s;
   logic [31:0]    rdt_s;

   // Address decode and write-commit qualification
   always_comb begin
      glob_s = i_wb_adr[AW-1];
      low_s  = i_wb_adr[AW-2:0];
      ch_s   = CHW'(low_s >> 2'd2);
      reg_s  = low_s[1:0];
      // A write takes effect only in the acknowledged cycle.
      wr_s   = i_wb_cyc & i_wb_we & ack_q;
      w1c_s  = wr_s & glob_s & (low_s == G_STATUS);
   end

   // Per-channel write strobes, prescaler tick and compare match
   always_comb begin
      ctl_wr_s = {NCH{1'b0}};
      cmp_wr_s = {NCH{1'b0}};
      cnt_wr_s = {NCH{1'b0}};
      tick_s   = {NCH{1'b0}};
      match_s  = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         ctl_wr_s[i] = wr_s & ~glob_s & (ch_s == CHW'(i)) & (reg_s == R_CTRL);
         cmp_wr_s[i] = wr_s & ~glob_s & (ch_s == CHW'(i)) & (reg_s == R_CMP);
         cnt_wr_s[i] = wr_s & ~glob_s & (ch_s == CHW'(i)) & (reg_s == R_CNT);
         tick_s[i]   = en_q[i] & (pre_q[i] == presc_q[i]);
         // A counter load in the same cycle takes precedence over matching.
         match_s[i]  = tick_s[i] & ~cnt_wr_s[i] & (cnt_q[i] == cmp_q[i]);
      end
   end

   // Next-state for bus acknowledge and all channel registers
   always_comb begin
      ack_d    = i_wb_cyc & ~ack_q;
      status_d = status_q;
      en_d     = en_q;
      os_d     = os_q;
      ie_d     = ie_q;
      for (int i = 0; i < NCH; i++) begin
         presc_d[i] = presc_q[i];
         pre_d[i]   = pre_q[i];
         cmp_d[i]   = cmp_q[i];
         cnt_d[i]   = cnt_q[i];

         if (ctl_wr_s[i] | cnt_wr_s[i]) begin
            pre_d[i] = {PW{1'b0}};
         end else if (tick_s[i]) begin
            pre_d[i] = {PW{1'b0}};
         end else if (en_q[i]) begin
            pre_d[i] = pre_q[i] + PW'(1'b1);
         end else begin
            pre_d[i] = pre_q[i];
         end

         if (cnt_wr_s[i]) begin
            cnt_d[i] = i_wb_dat[CW-1:0];
         end else if (match_s[i]) begin
            cnt_d[i] = {CW{1'b0}};
         end else if (tick_s[i]) begin
            cnt_d[i] = cnt_q[i] + CW'(1'b1);
         end else begin
            cnt_d[i] = cnt_q[i];
         end

         // A bus write of CTRL wins over the one-shot auto-clear of en.
         if (ctl_wr_s[i]) begin
            en_d[i]    = i_wb_dat[0];
            os_d[i]    = i_wb_dat[1];
            ie_d[i]    = i_wb_dat[2];
            presc_d[i] = i_wb_dat[8 +: PW];
         end else begin
            en_d[i]    = en_q[i] & ~(match_s[i] & os_q[i]);
         end

         if (cmp_wr_s[i]) begin
            cmp_d[i] = i_wb_dat[CW-1:0];
         end else begin
            cmp_d[i] = cmp_q[i];
         end

         // Hardware set beats a same-cycle write-1-to-clear.
         status_d[i] = match_s[i] | (status_q[i] & ~(w1c_s & i_wb_dat[i]));
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q    <= 1'b0;
         status_q <= {NCH{1'b0}};
         en_q     <= {NCH{1'b0}};
         os_q     <= {NCH{1'b0}};
         ie_q     <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            presc_q[i] <= {PW{1'b0}};
            pre_q[i]   <= {PW{1'b0}};
            cmp_q[i]   <= {CW{1'b1}};
            cnt_q[i]   <= {CW{1'b0}};
         end
      end else begin
         ack_q    <= ack_d;
         status_q <= status_d;
         en_q     <= en_d;
         os_q     <= os_d;
         ie_q     <= ie_d;
         for (int i = 0; i < NCH; i++) begin
            presc_q[i] <= presc_d[i];
            pre_q[i]   <= pre_d[i];
            cmp_q[i]   <= cmp_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Read-data multiplexer
   always_comb begin
      rdt_s = 32'd0;
      if (glob_s) begin
         if (low_s == G_STATUS) begin
            rdt_s = 32'(status_q);
         end else if (low_s == G_ID) begin
            rdt_s = {16'(NCH), 8'(PW), 8'(CW)};
         end else begin
            rdt_s = 32'd0;
         end
      end else begin
         case (reg_s)
            R_CTRL:  rdt_s = (32'(presc_q[ch_s]) << 5'd8) |
                             {29'd0, ie_q[ch_s], os_q[ch_s], en_q[ch_s]};
            R_CMP:   rdt_s = 32'(cmp_q[ch_s]);
            R_CNT:   rdt_s = 32'(cnt_q[ch_s]);
            R_PRE:   rdt_s = 32'(pre_q[ch_s]);
            default: rdt_s = 32'd0;
         endcase
      end
   end

   assign o_wb_rdt  = rdt_s;
   assign o_wb_ack  = ack_q;
   assign o_int_vec = status_q & ie_q;
   assign o_int     = |(status_q & ie_q);

endmodule

// File: tb/tb_timer_array.sv
// ---------------------------------------------------------------------------
// tb_timer_array
//   Two instances share one bus: a default build (NCH=4, CW=32, PW=8) that is
//   tracked cycle by cycle by a behavioural model, and a CW=8 build checked
//   against hand-computed constants for width truncation and wrap behaviour.
// ---------------------------------------------------------------------------
module tb_timer_array;

   localparam int NCH = 4;
   localparam int CW  = 32;
   localparam int PW  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  adr = 5'd0;
   logic [31:0] dat = 32'd0;
   logic        we  = 1'b0;
   logic        cyc = 1'b0;

   logic [31:0] rdt,  rdt8;
   logic        ack,  ack8;
   logic [3:0]  iv,   iv8;
   logic        irq,  irq8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   timer_array #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
      .clk(clk), .rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
      .i_wb_cyc(cyc), .o_wb_rdt(rdt), .o_wb_ack(ack), .o_int_vec(iv), .o_int(irq)
   );

   timer_array #(.NCH(NCH), .CW(8), .PW(PW)) dut8 (
      .clk(clk), .rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
      .i_wb_cyc(cyc), .o_wb_rdt(rdt8), .o_wb_ack(ack8), .o_int_vec(iv8), .o_int(irq8)
   );

   // ---------------- behavioural model of the CW=32 instance ----------------
   bit          m_en [NCH];
   bit          m_os [NCH];
   bit          m_ie [NCH];
   bit          m_st [NCH];
   int unsigned m_presc [NCH];
   int unsigned m_pre [NCH];
   logic [31:0] m_cmp [NCH];
   logic [31:0] m_cnt [NCH];
   bit          m_ack;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_st[i] = 0;
         m_presc[i] = 0; m_pre[i] = 0;
         m_cmp[i] = 32'hFFFF_FFFF; m_cnt[i] = 32'd0;
      end
      m_ack = 0;
   endtask

   // Advance the model by one clock edge using the bus inputs now applied.
   task automatic model_step();
      bit commit, glob, hit, tick, match, w1c;
      int ch, r;
      if (rst) begin
         model_reset();
         return;
      end
      commit = cyc && we && m_ack;
      glob   = adr[4];
      ch     = int'(adr[3:2]);
      r      = int'(adr[1:0]);
      w1c    = commit && glob && (adr[3:0] == 4'd0);
      for (int i = 0; i < NCH; i++) begin
         hit   = commit && !glob && (ch == i);
         // An enabled channel ticks once every presc+1 cycles.
         tick  = m_en[i] && (m_pre[i] == m_presc[i]);
         match = tick && !(hit && r == 2) && (m_cnt[i] == m_cmp[i]);
         if (m_en[i]) m_pre[i] = tick ? 0 : m_pre[i] + 1;
         if (tick) m_cnt[i] = match ? 32'd0 : m_cnt[i] + 32'd1;
         if (match) begin
            m_st[i] = 1;
            if (m_os[i]) m_en[i] = 0;
         end else if (w1c && dat[i]) begin
            m_st[i] = 0;
         end
         // Bus writes land last and override the counting above.
         if (hit) begin
            case (r)
               0: begin
                  m_en[i] = dat[0]; m_os[i] = dat[1]; m_ie[i] = dat[2];
                  m_presc[i] = int'(dat[15:8]); m_pre[i] = 0;
               end
               1: m_cmp[i] = dat;
               2: begin m_cnt[i] = dat; m_pre[i] = 0; end
               default: ;
            endcase
         end
      end
      m_ack = cyc && !m_ack;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      int c;
      logic [31:0] s;
      c = int'(a[3:2]);
      s = 32'd0;
      if (a[4]) begin
         if (a[3:0] == 4'd0) begin
            for (int i = 0; i < NCH; i++) s[i] = m_st[i];
            return s;
         end else if (a[3:0] == 4'd1) begin
            return 32'h0004_0820;
         end
         return 32'd0;
      end
      case (a[1:0])
         2'd0: return 32'(m_presc[c] * 256 + 4 * int'(m_ie[c]) + 2 * int'(m_os[c]) + int'(m_en[c]));
         2'd1: return m_cmp[c];
         2'd2: return m_cnt[c];
         default: return 32'(m_pre[c]);
      endcase
   endfunction

   function automatic logic [3:0] model_irq();
      logic [3:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_st[i] & m_ie[i];
      return v;
   endfunction

   // Compare outputs against the model, then clock DUT and model together.
   task automatic cycle();
      logic [3:0] miv;
      #1;
      miv = model_irq();
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      chk($sformatf("rdt@%0d", adr), rdt, model_read(adr));
      chk("int_vec", {28'd0, iv}, {28'd0, miv});
      chk("int", {31'd0, irq}, {31'd0, |miv});
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      adr = a; dat = d; we = 1'b1; cyc = 1'b1;
      cycle();
      cycle();
      cyc = 1'b0; we = 1'b0;
   endtask

   typedef struct packed {
      logic        wr;
      logic [4:0]  adr;
      logic [31:0] dat;
      logic [31:0] exp;
      logic [31:0] exp8;
   } vec_t;

   vec_t tbl [12];

   logic [31:0] cnt_seq [9];
   logic [31:0] cnt_seq8 [4];

   initial begin
      tbl[0]  = '{1'b0, 5'h11, 32'h0,         32'h0004_0820, 32'h0004_0808};
      tbl[1]  = '{1'b0, 5'h01, 32'h0,         32'hFFFF_FFFF, 32'h0000_00FF};
      tbl[2]  = '{1'b0, 5'h10, 32'h0,         32'h0000_0000, 32'h0000_0000};
      tbl[3]  = '{1'b1, 5'h0C, 32'hFFFF_FFF8, 32'h0000_FF00, 32'h0000_FF00};
      tbl[4]  = '{1'b1, 5'h09, 32'h1234_5678, 32'h1234_5678, 32'h0000_0078};
      tbl[5]  = '{1'b0, 5'h0A, 32'h0,         32'h0000_0000, 32'h0000_0000};
      tbl[6]  = '{1'b1, 5'h06, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_00EF};
      tbl[7]  = '{1'b0, 5'h02, 32'h0,         32'h0000_0000, 32'h0000_0000};
      tbl[8]  = '{1'b0, 5'h12, 32'h0,         32'h0000_0000, 32'h0000_0000};
      tbl[9]  = '{1'b1, 5'h00, 32'hFFFF_0106, 32'h0000_0106, 32'h0000_0106};
      tbl[10] = '{1'b0, 5'h03, 32'h0,         32'h0000_0000, 32'h0000_0000};
      tbl[11] = '{1'b1, 5'h00, 32'h0,         32'h0000_0000, 32'h0000_0000};

      // ---------------- reset state ----------------
      model_reset();
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      chk("reset_int", {31'd0, irq}, 32'd0);
      chk("reset_ack", {31'd0, ack}, 32'd0);
      chk("reset_vec8", {28'd0, iv8}, 32'd0);

      // ---------------- register table ----------------
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].wr) bus_write(tbl[i].adr, tbl[i].dat);
         adr = tbl[i].adr; we = 1'b0; cyc = 1'b1;
         cycle();
         #1;
         chk($sformatf("vec%0d", i), rdt, tbl[i].exp);
         chk($sformatf("vec%0d_cw8", i), rdt8, tbl[i].exp8);
         cyc = 1'b0;
         cycle();
      end

      // ---------------- periodic count and sticky flag ----------------
      bus_write(5'h01, 32'd3);
      bus_write(5'h00, 32'h5);
      adr = 5'h02;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("per_cnt%0d", k), rdt, (k == 4) ? 32'd0 : 32'(k));
         chk($sformatf("per_int%0d", k), {31'd0, irq}, (k == 4) ? 32'd1 : 32'd0);
         cycle();
      end
      cycle(); cycle(); cycle();
      chk("per_hold_int", {31'd0, irq}, 32'd1);
      bus_write(5'h00, 32'h4);
      bus_write(5'h10, 32'h1);
      #1;
      chk("per_w1c_int", {31'd0, irq}, 32'd0);

      // ---------------- W1C colliding with a match ----------------
      bus_write(5'h02, 32'd0);
      bus_write(5'h00, 32'h5);
      cycle(); cycle();
      bus_write(5'h10, 32'h1);
      #1;
      chk("coll_status", rdt, 32'h1);
      chk("coll_int", {31'd0, irq}, 32'd1);
      bus_write(5'h00, 32'h4);
      bus_write(5'h10, 32'h1);
      #1;
      chk("coll_clr_status", rdt, 32'h0);
      chk("coll_clr_int", {31'd0, irq}, 32'd0);

      // ---------------- one-shot with prescaler ----------------
      cnt_seq = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
      bus_write(5'h06, 32'd0);
      bus_write(5'h05, 32'd1);
      bus_write(5'h04, 32'h0000_0203);
      adr = 5'h06;
      for (int k = 0; k < 9; k++) begin
         #1;
         chk($sformatf("os_cnt%0d", k), rdt, cnt_seq[k]);
         cycle();
      end
      adr = 5'h04;
      #1;
      chk("os_ctrl", rdt, 32'h0000_0202);
      adr = 5'h10;
      #1;
      chk("os_status", rdt, 32'h2);

      // ---------------- interrupt gating by ie ----------------
      bus_write(5'h0A, 32'd0);
      bus_write(5'h09, 32'd0);
      bus_write(5'h08, 32'h1);
      cycle(); cycle();
      adr = 5'h10;
      #1;
      chk("ie_status", rdt, 32'h6);
      chk("ie_vec_off", {28'd0, iv}, 32'h0);
      bus_write(5'h08, 32'h4);
      #1;
      chk("ie_vec_on", {28'd0, iv}, 32'h4);
      chk("ie_int_on", {31'd0, irq}, 32'd1);
      bus_write(5'h08, 32'h0);
      bus_write(5'h10, 32'hF);
      #1;
      chk("ie_int_clr", {31'd0, irq}, 32'd0);

      // ---------------- CW=8 wrap and truncation ----------------
      cnt_seq8 = '{32'hFE, 32'hFF, 32'h00, 32'h01};
      bus_write(5'h0D, 32'hFF);
      bus_write(5'h0E, 32'hFE);
      bus_write(5'h0C, 32'h1);
      adr = 5'h0E;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("cw8_cnt%0d", k), rdt8, cnt_seq8[k]);
         cycle();
      end
      bus_write(5'h0E, 32'h1234_5600);
      #1;
      chk("cw8_trunc", rdt8, 32'h0);
      chk("cw32_full", rdt, 32'h1234_5600);
      adr = 5'h10;
      #1;
      chk("cw8_status3", {31'd0, rdt8[3]}, 32'd1);
      bus_write(5'h0C, 32'h0);
      bus_write(5'h10, 32'hF);

      // ---------------- asynchronous reset mid-count ----------------
      bus_write(5'h01, 32'd3);
      bus_write(5'h02, 32'd0);
      bus_write(5'h00, 32'h5);
      for (int k = 0; k < 5; k++) cycle();
      adr = 5'h02; we = 1'b0; cyc = 1'b1;
      cycle();
      #1;
      chk("pre_rst_cnt", rdt, 32'd2);
      chk("pre_rst_ack", {31'd0, ack}, 32'd1);
      chk("pre_rst_int", {31'd0, irq}, 32'd1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_int", {31'd0, irq}, 32'd0);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_cnt", rdt, 32'd0);
      cyc = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      adr = 5'h01;
      #1;
      chk("post_rst_cmp", rdt, 32'hFFFF_FFFF);
      chk("post_rst_cmp8", rdt8, 32'h0000_00FF);
      cyc = 1'b1;
      #1;
      chk("post_rst_ack0", {31'd0, ack}, 32'd0);
      cycle();
      chk("post_rst_ack1", {31'd0, ack}, 32'd1);
      cyc = 1'b0;
      cycle();

      // ---------------- randomized bus traffic against the model ----------------
      for (int n = 0; n < 1500; n++) begin
         cyc = ($urandom_range(0, 3) != 0);
         we  = ($urandom_range(0, 1) == 1);
         adr = 5'($urandom_range(0, 31));
         if (adr[4]) begin
            adr[3:0] = 4'($urandom_range(0, 2));
            dat = $urandom;
         end else if (adr[1:0] == 2'd0) begin
            dat = 32'($urandom_range(0, 2) * 256 + $urandom_range(0, 7));
         end else if ($urandom_range(0, 7) == 0) begin
            dat = $urandom;
         end else begin
            dat = 32'($urandom_range(0, 6));
         end
         cycle();
      end
      cyc = 1'b0; we = 1'b0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent timer channels (power of 2, 1..16).
REQ-002 SHALL have parameter CW, default 32, counter/compare width (8..32).
REQ-003 SHALL have parameter PW, default 8, prescaler width (1..16).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_wb_adr  input  $clog2(NCH)+3  word address: bit MSB=1 global space, else {channel, reg[1:0]}.
REQ-007 SHALL have port i_wb_dat  input  32  write data.
REQ-008 SHALL have port i_wb_we  input  1  write enable.
REQ-009 SHALL have port i_wb_cyc  input  1  bus cycle request.
REQ-010 SHALL have port o_wb_rdt  output  32  read data.
REQ-011 SHALL have port o_wb_ack  output  1  one-cycle acknowledge.
REQ-012 SHALL have port o_int_vec  output  NCH  per-channel interrupt, status[i] & ie[i].
REQ-013 SHALL have port o_int  output  1  OR of o_int_vec.

Function
REQ-014 SHALL register o_wb_ack <= i_wb_cyc & ~o_wb_ack: ack one cycle after cyc, never two consecutive cycles.
REQ-015 SHALL commit a write only in the cycle i_wb_cyc & i_wb_we & o_wb_ack is high.
REQ-016 SHALL drive o_wb_rdt combinationally from i_wb_adr; unused bits and unmapped addresses read 0.
REQ-017 SHALL map per channel: reg0 CTRL {bit0 en, bit1 oneshot, bit2 ie, bits[8+PW-1:8] presc}, reg1 CMP, reg2 CNT (read-write), reg3 PRE_CNT (read-only prescaler value).
REQ-018 SHALL map global word 0 STATUS: bit i = channel i match flag; write-1-to-clear; global word 1 reads constant {16'(NCH), 8'(PW), 8'(CW)}.
REQ-019 SHALL, per enabled channel, increment the prescaler each cycle and assert tick and reset the prescaler to 0 when prescaler == presc (presc=0 => tick every cycle).
REQ-020 SHALL, on tick: if CNT == CMP then CNT <= 0, STATUS[i] <= 1, and en <= 0 when oneshot; else CNT <= CNT+1 (modulo 2^CW).
REQ-021 SHALL hold CNT and prescaler unchanged while en=0 (no clearing on disable).
REQ-022 SHALL, on CNT write, load i_wb_dat[CW-1:0], reset prescaler to 0, and suppress that cycle's count/match update for that channel.
REQ-023 SHALL, on CTRL write, update en/oneshot/ie/presc and reset prescaler to 0; CNT unaffected.
REQ-024 SHALL give a same-cycle hardware match priority over a STATUS write-1-to-clear of the same bit (flag stays 1).
REQ-025 SHALL give a bus write of en=1 priority over a same-cycle oneshot auto-clear of en.
REQ-026 SHALL ignore write data bits above CW in CMP/CNT and above field widths in CTRL.
REQ-027 SHALL make channels fully independent; one write affects only the addressed channel.

Reset
REQ-028 SHALL, on rst high, asynchronously set CTRL=0, CMP=all ones, CNT=0, prescaler=0, STATUS=0, o_wb_ack=0; thus o_int_vec=0 and o_int=0.
REQ-029 SHALL abandon any in-flight bus cycle on reset; the next cyc after release is acked one cycle later.

Verification
REQ-030 SHALL pass: ch0 CMP=3, CTRL=en|ie, presc=0 -> CNT 0,1,2,3,0; STATUS[0] and o_int high from cycle after CNT==3 tick; persists until W1C.
REQ-031 SHALL pass: ch1 CMP=1, presc=2, oneshot|en -> CNT increments every 3rd cycle, single match, en reads 0, CNT stays 0, STATUS[1]=1.
REQ-032 SHALL pass: STATUS W1C of bit0 in the same cycle ch0 matches -> STATUS[0] stays 1; W1C next cycle -> 0, o_int deasserts.
REQ-033 SHALL pass: CW=8, CMP=8'hFF, CNT written 8'hFE -> 8'hFF, match, wrap to 0; write 32'h1234_5600 to CNT reads back 32'h0000_0000.
REQ-034 SHALL pass: rst asserted mid-count with ie set -> o_int, o_wb_ack, CNT drop same cycle; CMP reads 32'hFFFF_FFFF after release.
REQ-035 SHALL pass: ch2 ie=0 while matching -> STATUS[2]=1 but o_int_vec[2]=0; setting ie=1 raises o_int_vec[2] next cycle.
